// File: rtl/inert_pkg.sv
// Shared FSM state type and default tuning constants for the inertial pitch integrator.
package inert_pkg;

    typedef enum logic {
        CAL = 1'b0,
        RUN = 1'b1
    } state_e;

    localparam logic [15:0] AZ_OFFSET   = 16'h00A0;
    localparam logic [8:0]  ACC_FUDGE   = 9'h1C0;
    localparam int          FUSION_STEP = 512;

endpackage

// File: rtl/inert_sat_add.sv
// IW-bit signed adder that clamps to the most positive/negative value instead of wrapping.
module inert_sat_add #(
    parameter int IW = 27
) (
    input  logic signed [IW-1:0] a,
    input  logic signed [IW-1:0] b,
    output logic signed [IW-1:0] sum
);

    function automatic logic signed [IW-1:0] sat_add(input logic signed [IW-1:0] x,
                                                     input logic signed [IW-1:0] y);
        logic signed [IW:0] s;
        s = (IW+1)'(x) + (IW+1)'(y);
        // Overflow shows up as disagreement between the guard bit and the IW-bit sign.
        if (s[IW] != s[IW-1]) begin
            return s[IW] ? {1'b1, {(IW-1){1'b0}}} : {1'b0, {(IW-1){1'b1}}};
        end
        return s[IW-1:0];
    endfunction

    assign sum = sat_add(a, b);

endmodule

// File: rtl/inertial_integrator_p.sv
// Gyro pitch integrator with gyro-offset calibration; optional accel fusion when INERT_FUSION_EN is defined.
module inertial_integrator_p #(
    parameter int             DW          = 16,
    parameter int             IW          = 27,
    parameter int             CAL_LOG2    = 4,
    parameter logic [DW-1:0]  AZ_OFFSET   = inert_pkg::AZ_OFFSET,
    parameter logic [8:0]     ACC_FUDGE   = inert_pkg::ACC_FUDGE,
    parameter int             FUSION_STEP = inert_pkg::FUSION_STEP
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 vld,
    input  logic signed [DW-1:0] ptch_rt,
    input  logic signed [DW-1:0] AZ,
    input  logic                 cal_req,
    output logic signed [DW-1:0] ptch,
    output logic                 ptch_vld,
    output logic                 cal_done
);

    import inert_pkg::*;

    localparam int AW = DW + CAL_LOG2;

    state_e                 state_q, state_d;
    logic [CAL_LOG2-1:0]    cnt_q, cnt_d;
    logic signed [AW-1:0]   acc_q, acc_d;
    logic signed [DW-1:0]   offset_q, offset_d;
    logic signed [IW-1:0]   integ_q, integ_d;
    logic signed [DW-1:0]   ptch_q, ptch_d;
    logic                   ptch_vld_q, ptch_vld_d;

    logic signed [AW-1:0]   acc_next;
    logic signed [DW:0]     comp;
    logic signed [IW-1:0]   fusion;
    logic signed [IW-1:0]   delta;
    logic signed [IW-1:0]   integ_sum;

    assign acc_next = acc_q + AW'(ptch_rt);
    assign comp     = (DW+1)'(ptch_rt) - (DW+1)'(offset_q);

`ifdef INERT_FUSION_EN
    logic signed [DW:0]    az_diff;
    logic signed [DW+10:0] az_prod;
    logic signed [DW+10:0] ptch_acc;

    assign az_diff  = (DW+1)'(AZ) - (DW+1)'(signed'(AZ_OFFSET));
    assign az_prod  = (DW+11)'(az_diff) * (DW+11)'(signed'({1'b0, ACC_FUDGE}));
    assign ptch_acc = az_prod >>> 13;
    // Nudge the integrator toward the accelerometer pitch by a fixed step each sample.
    assign fusion   = (ptch_acc > (DW+11)'(ptch_q)) ? IW'(FUSION_STEP) : -IW'(FUSION_STEP);
`else
    logic unused_cfg;

    assign unused_cfg = ^{AZ, AZ_OFFSET, ACC_FUDGE} ^ FUSION_STEP[0];
    assign fusion     = '0;
`endif

    assign delta = fusion - IW'(comp);

    inert_sat_add #(
        .IW (IW)
    ) u_sat_add (
        .a   (integ_q),
        .b   (delta),
        .sum (integ_sum)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        offset_d   = offset_q;
        integ_d    = integ_q;
        ptch_d     = ptch_q;
        ptch_vld_d = 1'b0;

        case (state_q)
            CAL: begin
                ptch_d = '0;
                if (cal_req) begin
                    acc_d = '0;
                    cnt_d = '0;
                end else if (vld) begin
                    acc_d = acc_next;
                    cnt_d = cnt_q + CAL_LOG2'(1);
                    if (cnt_q == '1) begin
                        offset_d = DW'(acc_next >>> CAL_LOG2);
                        integ_d  = '0;
                        acc_d    = '0;
                        cnt_d    = '0;
                        state_d  = RUN;
                    end
                end
            end
            RUN: begin
                // A recalibration request discards any sample arriving in the same cycle.
                if (cal_req) begin
                    state_d = CAL;
                    acc_d   = '0;
                    cnt_d   = '0;
                    integ_d = '0;
                    ptch_d  = '0;
                end else if (vld) begin
                    integ_d    = integ_sum;
                    ptch_d     = integ_sum[IW-1:IW-DW];
                    ptch_vld_d = 1'b1;
                end
            end
            default: state_d = CAL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= CAL;
            cnt_q      <= '0;
            acc_q      <= '0;
            offset_q   <= '0;
            integ_q    <= '0;
            ptch_q     <= '0;
            ptch_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            offset_q   <= offset_d;
            integ_q    <= integ_d;
            ptch_q     <= ptch_d;
            ptch_vld_q <= ptch_vld_d;
        end
    end

    assign ptch     = ptch_q;
    assign ptch_vld = ptch_vld_q;
    assign cal_done = (state_q == RUN);

endmodule

// File: tb/tb_inertial_integrator_p.sv
// Directed bench for inertial_integrator_p: vector table for run-mode integration, hand sequences for calibration corners.
module tb_inertial_integrator_p;

    logic        clk;
    logic        rst;
    logic        vld;
    logic [15:0] ptch_rt;
    logic [15:0] AZ;
    logic        cal_req;
    logic [15:0] ptch;
    logic        ptch_vld;
    logic        cal_done;

    int checks = 0;
    int errors = 0;

    inertial_integrator_p dut (
        .clk      (clk),
        .rst      (rst),
        .vld      (vld),
        .ptch_rt  (ptch_rt),
        .AZ       (AZ),
        .cal_req  (cal_req),
        .ptch     (ptch),
        .ptch_vld (ptch_vld),
        .cal_done (cal_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [15:0] rt;
        int          n;
        logic [15:0] exp_ptch;
        int          exp_pulses;
        logic        exp_done;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drives n back-to-back vld samples and counts ptch_vld pulses seen after each edge.
    task automatic apply(input int n, input logic [15:0] rt, output int pulses);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            vld     = 1'b1;
            ptch_rt = rt;
            @(posedge clk);
            #1;
            if (ptch_vld) pulses++;
        end
        vld = 1'b0;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    int p;

    initial begin
        vecs[0] = '{"cal16",      16'h03C2,   16, 16'h0000,    0, 1'b1};
        vecs[1] = '{"ramp_down",  16'h13C2,  512, 16'hFC00,  512, 1'b1};
        vecs[2] = '{"hold",       16'h03C2, 1000, 16'hFC00, 1000, 1'b1};
        vecs[3] = '{"ramp_up",    16'hFBC2, 1024, 16'h0000, 1024, 1'b1};
        vecs[4] = '{"small_up",   16'hFBC2,    3, 16'h0003,    3, 1'b1};
        vecs[5] = '{"sat_pos",    16'h83C2, 3000, 16'h7FFF, 3000, 1'b1};
        vecs[6] = '{"sat_hold",   16'h83C2,  100, 16'h7FFF,  100, 1'b1};
        vecs[7] = '{"sat_neg",    16'h7FFF, 5000, 16'h8000, 5000, 1'b1};

        rst     = 1'b1;
        vld     = 1'b0;
        ptch_rt = '0;
        AZ      = '0;
        cal_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_ptch", 32'(ptch), 32'h0);
        chk("reset_ptch_vld", 32'(ptch_vld), 32'h0);
        chk("reset_cal_done", 32'(cal_done), 32'h0);

        // Partial calibration must not raise cal_done early.
        apply(15, 16'h03C2, p);
        chk("cal15_done", 32'(cal_done), 32'h0);
        apply(1, 16'h03C2, p);
        chk("cal16_early_done", 32'(cal_done), 32'h1);
        pulse_rst();
        chk("rst_after_cal_done", 32'(cal_done), 32'h0);

        for (int v = 0; v < 8; v++) begin
            apply(vecs[v].n, vecs[v].rt, p);
            chk({vecs[v].name, "_ptch"}, 32'(ptch), 32'(vecs[v].exp_ptch));
            chk({vecs[v].name, "_pulses"}, 32'(p), 32'(vecs[v].exp_pulses));
            chk({vecs[v].name, "_done"}, 32'(cal_done), 32'(vecs[v].exp_done));
            @(posedge clk);
            #1;
            chk({vecs[v].name, "_vld_drop"}, 32'(ptch_vld), 32'h0);
        end

        // cal_req together with vld in RUN: sample discarded, full recalibration needed.
        cal_req = 1'b1;
        vld     = 1'b1;
        ptch_rt = 16'h7FFF;
        @(posedge clk);
        #1;
        cal_req = 1'b0;
        vld     = 1'b0;
        chk("calreq_ptch", 32'(ptch), 32'h0);
        chk("calreq_done", 32'(cal_done), 32'h0);
        chk("calreq_vld", 32'(ptch_vld), 32'h0);
        apply(15, 16'h0100, p);
        chk("recal15_done", 32'(cal_done), 32'h0);
        chk("recal15_pulses", 32'(p), 32'h0);
        apply(1, 16'h0100, p);
        chk("recal16_done", 32'(cal_done), 32'h1);
        chk("recal16_pulses", 32'(p), 32'h0);
        apply(1, 16'h0900, p);
        chk("recal_offset_ptch", 32'(ptch), 32'hFFFF);
        chk("recal_offset_pulses", 32'(p), 32'h1);

        // rst mid-run, then rst again mid-calibration.
        pulse_rst();
        chk("rst_run_ptch", 32'(ptch), 32'h0);
        chk("rst_run_done", 32'(cal_done), 32'h0);
        apply(8, 16'h0010, p);
        pulse_rst();
        chk("rst_cal_ptch", 32'(ptch), 32'h0);
        chk("rst_cal_vld", 32'(ptch_vld), 32'h0);
        chk("rst_cal_done", 32'(cal_done), 32'h0);
        apply(15, 16'h0010, p);
        chk("rst_cal15_done", 32'(cal_done), 32'h0);
        apply(1, 16'h0010, p);
        chk("rst_cal16_done", 32'(cal_done), 32'h1);
        apply(1, 16'h0010, p);
        chk("rst_offset_ptch", 32'(ptch), 32'h0);
        chk("rst_offset_pulses", 32'(p), 32'h1);
        apply(1, 16'h0410, p);
        chk("rst_offset_step", 32'(ptch), 32'hFFFF);

        // cal_req in CAL restarts the count and drops the partial accumulation.
        cal_req = 1'b1;
        @(posedge clk);
        #1;
        cal_req = 1'b0;
        apply(8, 16'h0400, p);
        cal_req = 1'b1;
        @(posedge clk);
        #1;
        cal_req = 1'b0;
        apply(15, 16'h0020, p);
        chk("restart15_done", 32'(cal_done), 32'h0);
        apply(1, 16'h0020, p);
        chk("restart16_done", 32'(cal_done), 32'h1);
        apply(4, 16'h0820, p);
        chk("restart_offset_ptch", 32'(ptch), 32'hFFFC);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
